// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
//   ID/EX pipeline register of the 5-stage MIPS core. It registers the decoded
//   controls, operands and register addresses of the instruction in ID and
//   presents them to EX one cycle later. A load-use hazard or a branch/jump
//   flush loads a bubble: a NOP whose controls, data and addresses are all
//   zero, so that $0 never matches in the hazard or forwarding comparators.
//
//   Optional feature macro: ID_EX_BUBBLE_CNT_EN
//     When this macro is defined, a saturating bubble counter and the
//     bubble_cnt_o port are added. When it is undefined, both are absent and
//     all other behaviour is identical.
//
// Ports
//   clk_i          core clock, rising edge
//   rst_i          synchronous reset, active-low
//   hazard_i       load-use hazard: load a bubble (ignored while stalled)
//   flush_i        branch/jump flush: load a bubble (beats stall_i)
//   stall_i        EX/MEM back-pressure: hold every register
//   ID_*_i         decoded controls, operands and addresses from ID
//   EX_*_o         registered copies of the ID_*_i inputs
//   EX_wbAddr_o    registered write-back address (regDst ? rd : rt)
//   EX_valid_o     1: EX holds a real instruction, 0: bubble
//   bubble_cnt_o   saturating count of bubbles loaded (macro builds only)
// -----------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hazard_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              ID_regWrite_i,
    input  logic              ID_memToReg_i,
    input  logic              ID_memRead_i,
    input  logic              ID_memWrite_i,
    input  logic              ID_aluSrc_i,
    input  logic [1:0]        ID_aluOp_i,
    input  logic              ID_regDst_i,
    input  logic [DATA_W-1:0] ID_rsData_i,
    input  logic [DATA_W-1:0] ID_rtData_i,
    input  logic [DATA_W-1:0] ID_imm_i,
    input  logic [ADDR_W-1:0] ID_rsAddr_i,
    input  logic [ADDR_W-1:0] ID_rtAddr_i,
    input  logic [ADDR_W-1:0] ID_rdAddr_i,
    output logic              EX_regWrite_o,
    output logic              EX_memToReg_o,
    output logic              EX_memRead_o,
    output logic              EX_memWrite_o,
    output logic              EX_aluSrc_o,
    output logic [1:0]        EX_aluOp_o,
    output logic              EX_regDst_o,
    output logic [DATA_W-1:0] EX_rsData_o,
    output logic [DATA_W-1:0] EX_rtData_o,
    output logic [DATA_W-1:0] EX_imm_o,
    output logic [ADDR_W-1:0] EX_rsAddr_o,
    output logic [ADDR_W-1:0] EX_rtAddr_o,
    output logic [ADDR_W-1:0] EX_rdAddr_o,
    output logic [ADDR_W-1:0] EX_wbAddr_o,
    output logic              EX_valid_o
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

    // -------------------------------------------------------------------------
    // Pipeline state
    // -------------------------------------------------------------------------
    logic              regWrite_q, regWrite_d;
    logic              memToReg_q, memToReg_d;
    logic              memRead_q,  memRead_d;
    logic              memWrite_q, memWrite_d;
    logic              aluSrc_q,   aluSrc_d;
    logic [1:0]        aluOp_q,    aluOp_d;
    logic              regDst_q,   regDst_d;
    logic [DATA_W-1:0] rsData_q,   rsData_d;
    logic [DATA_W-1:0] rtData_q,   rtData_d;
    logic [DATA_W-1:0] imm_q,      imm_d;
    logic [ADDR_W-1:0] rsAddr_q,   rsAddr_d;
    logic [ADDR_W-1:0] rtAddr_q,   rtAddr_d;
    logic [ADDR_W-1:0] rdAddr_q,   rdAddr_d;
    logic [ADDR_W-1:0] wbAddr_q,   wbAddr_d;
    logic              valid_q,    valid_d;

    // -------------------------------------------------------------------------
    // Edge action decode
    //   flush beats stall; stall beats hazard (the hazard unit keeps hazard_i
    //   asserted for as long as the hazard persists, so dropping it here is
    //   safe).
    // -------------------------------------------------------------------------
    logic load_bubble;
    logic hold;

    assign load_bubble = flush_i | (~stall_i & hazard_i);
    assign hold        = ~flush_i & stall_i;

    // -------------------------------------------------------------------------
    // Next-state selection: hold, bubble (all zero) or load from ID
    // -------------------------------------------------------------------------
    always_comb begin
        regWrite_d = regWrite_q;
        memToReg_d = memToReg_q;
        memRead_d  = memRead_q;
        memWrite_d = memWrite_q;
        aluSrc_d   = aluSrc_q;
        aluOp_d    = aluOp_q;
        regDst_d   = regDst_q;
        rsData_d   = rsData_q;
        rtData_d   = rtData_q;
        imm_d      = imm_q;
        rsAddr_d   = rsAddr_q;
        rtAddr_d   = rtAddr_q;
        rdAddr_d   = rdAddr_q;
        wbAddr_d   = wbAddr_q;
        valid_d    = valid_q;

        if (load_bubble) begin
            regWrite_d = 1'b0;
            memToReg_d = 1'b0;
            memRead_d  = 1'b0;
            memWrite_d = 1'b0;
            aluSrc_d   = 1'b0;
            aluOp_d    = '0;
            regDst_d   = 1'b0;
            rsData_d   = '0;
            rtData_d   = '0;
            imm_d      = '0;
            rsAddr_d   = '0;
            rtAddr_d   = '0;
            rdAddr_d   = '0;
            wbAddr_d   = '0;
            valid_d    = 1'b0;
        end else if (!hold) begin
            regWrite_d = ID_regWrite_i;
            memToReg_d = ID_memToReg_i;
            memRead_d  = ID_memRead_i;
            memWrite_d = ID_memWrite_i;
            aluSrc_d   = ID_aluSrc_i;
            aluOp_d    = ID_aluOp_i;
            regDst_d   = ID_regDst_i;
            rsData_d   = ID_rsData_i;
            rtData_d   = ID_rtData_i;
            imm_d      = ID_imm_i;
            rsAddr_d   = ID_rsAddr_i;
            rtAddr_d   = ID_rtAddr_i;
            rdAddr_d   = ID_rdAddr_i;
            // Destination is resolved here so the hazard unit sees a
            // registered address without a mux on its compare path.
            wbAddr_d   = ID_regDst_i ? ID_rdAddr_i : ID_rtAddr_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            regWrite_q <= 1'b0;
            memToReg_q <= 1'b0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            aluSrc_q   <= 1'b0;
            aluOp_q    <= '0;
            regDst_q   <= 1'b0;
            rsData_q   <= '0;
            rtData_q   <= '0;
            imm_q      <= '0;
            rsAddr_q   <= '0;
            rtAddr_q   <= '0;
            rdAddr_q   <= '0;
            wbAddr_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            regWrite_q <= regWrite_d;
            memToReg_q <= memToReg_d;
            memRead_q  <= memRead_d;
            memWrite_q <= memWrite_d;
            aluSrc_q   <= aluSrc_d;
            aluOp_q    <= aluOp_d;
            regDst_q   <= regDst_d;
            rsData_q   <= rsData_d;
            rtData_q   <= rtData_d;
            imm_q      <= imm_d;
            rsAddr_q   <= rsAddr_d;
            rtAddr_q   <= rtAddr_d;
            rdAddr_q   <= rdAddr_d;
            wbAddr_q   <= wbAddr_d;
            valid_q    <= valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs come straight from flops: no input-to-output combinational path
    // -------------------------------------------------------------------------
    assign EX_regWrite_o = regWrite_q;
    assign EX_memToReg_o = memToReg_q;
    assign EX_memRead_o  = memRead_q;
    assign EX_memWrite_o = memWrite_q;
    assign EX_aluSrc_o   = aluSrc_q;
    assign EX_aluOp_o    = aluOp_q;
    assign EX_regDst_o   = regDst_q;
    assign EX_rsData_o   = rsData_q;
    assign EX_rtData_o   = rtData_q;
    assign EX_imm_o      = imm_q;
    assign EX_rsAddr_o   = rsAddr_q;
    assign EX_rtAddr_o   = rtAddr_q;
    assign EX_rdAddr_o   = rdAddr_q;
    assign EX_wbAddr_o   = wbAddr_q;
    assign EX_valid_o    = valid_q;

`ifdef ID_EX_BUBBLE_CNT_EN
    // -------------------------------------------------------------------------
    // Saturating bubble counter: counts edges that load a bubble (flush, or
    // an un-stalled hazard), sticks at all-ones.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_bubble && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bubble_cnt_o = cnt_q;
`endif

endmodule
